// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect request / PC control bundle between the pipeline and the fetch redirect controller.
// No latency of its own; plain wires.
// No backpressure here; imem_ready and hazard_stall travel in-band as stall qualifiers.
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             imem_ready;
    logic             hazard_stall;
    logic             trap_req;
    logic [31:0]      trap_vector;
    logic             mret_req;
    logic [31:0]      mepc;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             jal_en;
    logic [31:0]      jal_target;
    logic             jump_en;
    logic [31:0]      jump_address;
    logic             pc_stall;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             misalign_trap;
    logic [CNT_W-1:0] redirect_cnt;

    // Requester side: pipeline, CSR logic and imem status drive it; it observes PC control.
    modport master (
        output imem_ready, hazard_stall, trap_req, trap_vector, mret_req, mepc,
               br_taken, br_target, jal_en, jal_target,
        input  jump_en, jump_address, pc_stall, flush_if, flush_id, flush_ex,
               misalign_trap, redirect_cnt
    );

    // Controller side.
    modport slave (
        input  imem_ready, hazard_stall, trap_req, trap_vector, mret_req, mepc,
               br_taken, br_target, jal_en, jal_target,
        output jump_en, jump_address, pc_stall, flush_if, flush_id, flush_ex,
               misalign_trap, redirect_cnt
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Merges trap/mret/branch/jal redirects by priority and drives PC jump/stall plus pipeline flushes.
// Latency: redirect appears on jump_en/jump_address the same cycle; traps redirect after TRAP_DRAIN frozen cycles.
// Backpressure: a redirect arriving while fetch cannot advance is held in HOLD until imem_ready and no hazard.
module fetch_redirect_ctrl #(
    parameter int TRAP_DRAIN = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  ctrl_io
);
    localparam int DW = (TRAP_DRAIN < 2) ? 1 : $clog2(TRAP_DRAIN + 1);

    // Priority ranks; a pending trap outranks every non-trap request.
    localparam logic [1:0] PRI_JAL  = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_MRET = 2'd2;
    localparam logic [1:0] PRI_TRAP = 2'd3;

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

    state_t           state_q;
    logic [31:0]      pend_q;
    logic [1:0]       pend_pri_q;
    logic [DW-1:0]    drain_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_vld, req_mis, acc_raw, acc_redir, take_trap, fetch_go, jump_en_c;
    logic [1:0]  req_pri;
    logic [31:0] req_tgt;

    // Pick the highest-priority non-trap request and decide whether it is taken this cycle.
    always_comb begin
        req_vld = 1'b0;
        req_pri = PRI_JAL;
        req_tgt = '0;
        if (ctrl_io.mret_req) begin
            req_vld = 1'b1;
            req_pri = PRI_MRET;
            req_tgt = ctrl_io.mepc;
        end else if (ctrl_io.br_taken) begin
            req_vld = 1'b1;
            req_pri = PRI_BR;
            req_tgt = ctrl_io.br_target;
        end else if (ctrl_io.jal_en) begin
            req_vld = 1'b1;
            req_pri = PRI_JAL;
            req_tgt = ctrl_io.jal_target;
        end
        // Only branch/jal targets are alignment-checked; mepc is trusted.
        req_mis   = req_vld && (req_pri <= PRI_BR) && (req_tgt[1:0] != 2'b00);
        // In HOLD, a lower-rank request is a wrong-path leftover and is ignored.
        acc_raw   = req_vld && !ctrl_io.trap_req && (state_q != DRAIN) &&
                    ((state_q == RUN) || (req_pri >= pend_pri_q));
        acc_redir = acc_raw && !req_mis;
        take_trap = ctrl_io.trap_req || (acc_raw && req_mis);
        fetch_go  = ctrl_io.imem_ready && !ctrl_io.hazard_stall && (state_q != DRAIN);
        jump_en_c = !take_trap && (acc_redir || (state_q == HOLD));
    end

    // PC control and flush outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        ctrl_io.jump_en       = 1'b0;
        ctrl_io.jump_address  = '0;
        ctrl_io.pc_stall      = 1'b0;
        ctrl_io.flush_if      = 1'b0;
        ctrl_io.flush_id      = 1'b0;
        ctrl_io.flush_ex      = 1'b0;
        ctrl_io.misalign_trap = 1'b0;
        ctrl_io.redirect_cnt  = '0;
        if (!reset) begin
            ctrl_io.jump_en       = jump_en_c;
            if (jump_en_c)
                ctrl_io.jump_address = acc_redir ? req_tgt : pend_q;
            ctrl_io.pc_stall      = !fetch_go;
            ctrl_io.flush_if      = (state_q == DRAIN) || take_trap || acc_redir;
            ctrl_io.flush_id      = (state_q == DRAIN) || take_trap || (acc_redir && req_pri >= PRI_BR);
            ctrl_io.flush_ex      = (state_q == DRAIN) || take_trap;
            ctrl_io.misalign_trap = acc_raw && req_mis;
            ctrl_io.redirect_cnt  = cnt_q;
        end
    end

    // Saturating count of redirects actually consumed by the PC.
    always_comb begin
        cnt_d = cnt_q;
        if (jump_en_c && fetch_go && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Sequencer: RUN / HOLD pending redirect / DRAIN before trap entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pend_q     <= '0;
            pend_pri_q <= PRI_JAL;
            drain_q    <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (take_trap) begin
                // Trap discards any pending redirect and (re)starts the drain.
                state_q    <= DRAIN;
                pend_q     <= ctrl_io.trap_vector;
                pend_pri_q <= PRI_TRAP;
                drain_q    <= DW'(TRAP_DRAIN);
            end else begin
                case (state_q)
                    RUN: begin
                        if (acc_redir && !fetch_go) begin
                            state_q    <= HOLD;
                            pend_q     <= req_tgt;
                            pend_pri_q <= req_pri;
                        end
                    end
                    HOLD: begin
                        if (acc_redir) begin
                            pend_q     <= req_tgt;
                            pend_pri_q <= req_pri;
                        end
                        if (fetch_go)
                            state_q <= RUN;
                    end
                    DRAIN: begin
                        if (drain_q <= DW'(1)) begin
                            state_q <= HOLD;
                            drain_q <= '0;
                        end else begin
                            drain_q <= drain_q - DW'(1);
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: hand-computed expectations checked with immediate assertions.
// Inputs change 1 time unit after a rising edge; outputs are checked mid-cycle.
// Clock period 10; the whole run is well under 100 cycles.
module tb_fetch_redirect_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();

    fetch_redirect_ctrl #(.TRAP_DRAIN(2), .CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_reqs();
        bus.trap_req = 1'b0;
        bus.mret_req = 1'b0;
        bus.br_taken = 1'b0;
        bus.jal_en   = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.imem_ready   = 1'b1;
        bus.hazard_stall = 1'b0;
        bus.trap_vector  = 32'h0;
        bus.mepc         = 32'h0;
        bus.br_target    = 32'h0;
        bus.jal_target   = 32'h0;
        clear_reqs();

        // Reset cycle and the cycle after: everything quiet.
        tick();
        settle();
        chk1("rst_jump_en", bus.jump_en, 1'b0);
        chk1("rst_pc_stall", bus.pc_stall, 1'b0);
        chk32("rst_cnt", 32'(bus.redirect_cnt), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk1("post_rst_jump_en", bus.jump_en, 1'b0);
        chk1("post_rst_flush_if", bus.flush_if, 1'b0);
        chk1("post_rst_pc_stall", bus.pc_stall, 1'b0);

        // 1: branch in RUN is taken the same cycle.
        tick();
        bus.br_taken = 1'b1; bus.br_target = 32'h100;
        settle();
        chk1("t1_jump_en", bus.jump_en, 1'b1);
        chk32("t1_addr", bus.jump_address, 32'h100);
        chk1("t1_flush_if", bus.flush_if, 1'b1);
        chk1("t1_flush_id", bus.flush_id, 1'b1);
        chk1("t1_flush_ex", bus.flush_ex, 1'b0);
        chk1("t1_pc_stall", bus.pc_stall, 1'b0);
        tick();
        clear_reqs();
        settle();
        chk32("t1_cnt", 32'(bus.redirect_cnt), 32'd1);
        chk1("t1_idle_jump_en", bus.jump_en, 1'b0);

        // Hazard stall alone stalls the PC.
        bus.hazard_stall = 1'b1;
        settle();
        chk1("hz_pc_stall", bus.pc_stall, 1'b1);
        tick();
        bus.hazard_stall = 1'b0;

        // 2: jal while imem not ready is held, then consumed once.
        bus.imem_ready = 1'b0;
        bus.jal_en = 1'b1; bus.jal_target = 32'h40;
        settle();
        chk1("t2_c0_jump_en", bus.jump_en, 1'b1);
        chk32("t2_c0_addr", bus.jump_address, 32'h40);
        chk1("t2_c0_pc_stall", bus.pc_stall, 1'b1);
        chk1("t2_c0_flush_if", bus.flush_if, 1'b1);
        chk1("t2_c0_flush_id", bus.flush_id, 1'b0);
        tick();
        clear_reqs();
        settle();
        chk1("t2_c1_jump_en", bus.jump_en, 1'b1);
        chk32("t2_c1_addr", bus.jump_address, 32'h40);
        chk1("t2_c1_flush_if", bus.flush_if, 1'b0);
        chk32("t2_c1_cnt", 32'(bus.redirect_cnt), 32'd1);
        tick();
        settle();
        chk1("t2_c2_pc_stall", bus.pc_stall, 1'b1);
        tick();
        bus.imem_ready = 1'b1;
        settle();
        chk1("t2_c3_jump_en", bus.jump_en, 1'b1);
        chk1("t2_c3_pc_stall", bus.pc_stall, 1'b0);
        tick();
        settle();
        chk1("t2_run_jump_en", bus.jump_en, 1'b0);
        chk32("t2_cnt", 32'(bus.redirect_cnt), 32'd2);

        // 3: higher-priority br overwrites a held jal; a later jal does not.
        bus.imem_ready = 1'b0;
        bus.jal_en = 1'b1; bus.jal_target = 32'h40;
        tick();
        clear_reqs();
        bus.br_taken = 1'b1; bus.br_target = 32'h80;
        settle();
        chk32("t3_br_addr", bus.jump_address, 32'h80);
        chk1("t3_br_flush_id", bus.flush_id, 1'b1);
        tick();
        clear_reqs();
        bus.jal_en = 1'b1; bus.jal_target = 32'h40;
        settle();
        chk32("t3_jal_ignored_addr", bus.jump_address, 32'h80);
        chk1("t3_jal_ignored_flush", bus.flush_if, 1'b0);
        tick();
        clear_reqs();
        bus.imem_ready = 1'b1;
        settle();
        chk1("t3_release_jump_en", bus.jump_en, 1'b1);
        chk32("t3_release_addr", bus.jump_address, 32'h80);
        tick();
        settle();
        chk32("t3_cnt", 32'(bus.redirect_cnt), 32'd3);

        // 4: trap drains two cycles, ignores branch, then redirects.
        bus.trap_req = 1'b1; bus.trap_vector = 32'h200;
        settle();
        chk1("t4_acc_jump_en", bus.jump_en, 1'b0);
        chk1("t4_acc_flush_ex", bus.flush_ex, 1'b1);
        tick();
        clear_reqs();
        bus.br_taken = 1'b1; bus.br_target = 32'h300;
        settle();
        chk1("t4_d1_pc_stall", bus.pc_stall, 1'b1);
        chk1("t4_d1_flush_ex", bus.flush_ex, 1'b1);
        chk1("t4_d1_jump_en", bus.jump_en, 1'b0);
        tick();
        settle();
        chk1("t4_d2_pc_stall", bus.pc_stall, 1'b1);
        chk1("t4_d2_flush_id", bus.flush_id, 1'b1);
        tick();
        clear_reqs();
        settle();
        chk1("t4_hold_jump_en", bus.jump_en, 1'b1);
        chk32("t4_hold_addr", bus.jump_address, 32'h200);
        chk1("t4_hold_flush_ex", bus.flush_ex, 1'b0);
        tick();
        settle();
        chk32("t4_cnt", 32'(bus.redirect_cnt), 32'd4);

        // 5a: trap + mret + br together take the trap path only.
        bus.trap_req = 1'b1; bus.trap_vector = 32'h240;
        bus.mret_req = 1'b1; bus.mepc = 32'h500;
        bus.br_taken = 1'b1; bus.br_target = 32'h104;
        settle();
        chk1("t5a_jump_en", bus.jump_en, 1'b0);
        chk1("t5a_flush_ex", bus.flush_ex, 1'b1);
        chk1("t5a_misalign", bus.misalign_trap, 1'b0);
        tick();
        clear_reqs();
        tick();
        tick();
        settle();
        chk32("t5a_hold_addr", bus.jump_address, 32'h240);
        tick();

        // 5b: misaligned branch becomes a trap to trap_vector.
        bus.br_taken = 1'b1; bus.br_target = 32'h102; bus.trap_vector = 32'h280;
        settle();
        chk1("t5b_misalign", bus.misalign_trap, 1'b1);
        chk1("t5b_jump_en", bus.jump_en, 1'b0);
        chk1("t5b_flush_ex", bus.flush_ex, 1'b1);
        tick();
        clear_reqs();
        settle();
        chk1("t5b_misalign_pulse_end", bus.misalign_trap, 1'b0);
        chk1("t5b_d1_pc_stall", bus.pc_stall, 1'b1);
        tick();
        tick();
        settle();
        chk1("t5b_hold_jump_en", bus.jump_en, 1'b1);
        chk32("t5b_hold_addr", bus.jump_address, 32'h280);
        tick();
        settle();
        chk32("t5b_cnt", 32'(bus.redirect_cnt), 32'd6);

        // 6: reset in the middle of DRAIN abandons the trap.
        bus.trap_req = 1'b1; bus.trap_vector = 32'h300;
        tick();
        clear_reqs();
        settle();
        chk1("t6_drain_pc_stall", bus.pc_stall, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.imem_ready = 1'b0;
        settle();
        chk1("t6_pc_stall_follows_imem", bus.pc_stall, 1'b1);
        chk1("t6_jump_en", bus.jump_en, 1'b0);
        chk1("t6_flush_ex", bus.flush_ex, 1'b0);
        chk32("t6_cnt", 32'(bus.redirect_cnt), 32'd0);
        bus.imem_ready = 1'b1;
        settle();
        chk1("t6_pc_stall_ready", bus.pc_stall, 1'b0);
        tick();
        settle();
        chk1("t6_no_trap_redirect", bus.jump_en, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
